// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its control-unit peer.
package inst_fetch_unit_pkg;

  localparam int INST_W_DEF      = 5;
  localparam int ADDR_W_DEF      = 8;
  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic [INST_W_DEF-1:0] NOP_OP = '0;

  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HOLD   = 2'd2,
    FETCH_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter; expired_o marks the LIMIT-th consecutive enabled cycle.
module fetch_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier enabled cycles, so this fires on cycle LIMIT
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/inst_fetch_unit.sv
// Program counter owner: fetches instruction words over req/ack and hands them
// to the control unit over valid/ready, honouring jumps and halts.
//
// state        | meaning
// FETCH_REQ    | raise mem_req for the word at pc, clear the wait counter
// FETCH_WAIT   | request outstanding, waiting for mem_ack or timeout
// FETCH_HOLD   | inst valid, waiting for the control unit to consume it
// FETCH_HALTED | stopped by halt or fetch timeout, left only via reset
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                INST_W      = INST_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_err_o
);

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              fetch_err_q, fetch_err_d;
  logic              flush_q, flush_d;
  logic              ctr_clr, ctr_en, ctr_expired;
  logic              ack_ok;

  assign ack_ok = mem_ack_i && mem_req_q;

  fetch_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .expired_o (ctr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FETCH_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        if (ack_ok) begin
          state_d = (flush_q || jump_en_i) ? FETCH_REQ : FETCH_HOLD;
        end else if (ctr_expired) begin
          state_d = FETCH_HALTED;
        end
      end
      FETCH_HOLD: begin
        if (inst_ready_i) begin
          state_d = halt_i ? FETCH_HALTED : FETCH_REQ;
        end
      end
      default: state_d = FETCH_HALTED;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    mem_req_d    = mem_req_q;
    fetch_err_d  = fetch_err_q;
    flush_d      = flush_q;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        mem_req_d = 1'b1;
        ctr_clr   = 1'b1;
        if (jump_en_i) pc_d = jump_addr_i;
      end
      FETCH_WAIT: begin
        ctr_en = 1'b1;
        if (ack_ok) begin
          mem_req_d = 1'b0;
          if (flush_q || jump_en_i) begin
            flush_d = 1'b0;
          end else begin
            inst_d       = mem_rdata_i;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 1'b1;
          end
        end else if (ctr_expired) begin
          fetch_err_d = 1'b1;
          mem_req_d   = 1'b0;
        end else if (jump_en_i) begin
          flush_d = 1'b1;
        end
        // a jump always wins over the post-fetch increment
        if (jump_en_i) pc_d = jump_addr_i;
      end
      FETCH_HOLD: begin
        if (jump_en_i) pc_d = jump_addr_i;
        if (inst_ready_i) inst_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q         <= RESET_PC;
      inst_q       <= INST_W'(NOP_OP);
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      fetch_err_q  <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      fetch_err_q  <= fetch_err_d;
      flush_q      <= flush_d;
    end
  end

  assign mem_addr_o   = pc_q;
  assign mem_req_o    = mem_req_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign pc_o         = pc_q;
  assign fetch_err_o  = fetch_err_q;

endmodule
